cw_encode: RTL and testbench



---
 rtl/cw_encode_pkg.sv | 26 ++
 rtl/cw_msg_buffer.sv | 44 ++++
 rtl/cw_encode.sv | 115 +++++++++++
 tb/tb_cw_encode.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cw_encode_pkg.sv
// Shared constants, state type and tap helper for the LDGM codeword encoder.
// Codeword is systematic: c = m * [I | P], parity taps on two circulant offsets.
package cw_encode_pkg;

    localparam int K      = 184;
    localparam int N      = 256;
    localparam int IDX_W  = 13;
    localparam int OFS1   = 61;
    localparam int OFS2   = 122;
    localparam int NBYTES = K / 8;
    localparam int NPAR   = N - K;
    localparam int CNT_W  = $clog2(NBYTES + 1);
    localparam int POS_W  = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Message bit feeding parity j through a circulant offset.
    function automatic int tap_idx(input int j, input int ofs);
        return (j + ofs) % K;
    endfunction

endpackage

// File: rtl/cw_msg_buffer.sv
// Write-only byte store for the encoder message; exposes the flat K-bit vector.
// Byte i, bit position k maps to message bit 8*i + (7 - k), i.e. MSB first.
module cw_msg_buffer
    import cw_encode_pkg::*;
(
    input  logic           clk,
    input  logic           rst_b,
    input  logic           wr_en,
    input  logic [7:0]     wr_byte,
    input  logic           clr,
    output logic           full,
    output logic [K-1:0]   msg
);

    logic [7:0]       mem [NBYTES];
    logic [CNT_W-1:0] count;

    assign full = (count == CNT_W'(NBYTES));

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            count <= '0;
            for (int i = 0; i < NBYTES; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            count <= '0;
        end else if (wr_en && !full) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (count == CNT_W'(i)) begin
                    mem[i] <= wr_byte;
                end
            end
            count <= count + 1'b1;
        end
    end

    for (genvar i = 0; i < NBYTES; i++) begin : g_byte
        for (genvar k = 0; k < 8; k++) begin : g_bit
            assign msg[8*i + k] = mem[i][7-k];
        end
    end

endmodule

// File: rtl/cw_encode.sv
// Streaming LDGM encoder: loads a K-bit message, walks the N codeword positions
// and strobes out the index of every set bit in ascending order.
//
//  state | meaning
//  IDLE  | loading bytes / waiting for start with a full buffer
//  RUN   | position counter sweeping 0..N-1, one position per cycle
//  DONE  | draining the tap pipeline, then cw_done and buffer clear
module cw_encode
    import cw_encode_pkg::*;
(
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic [7:0]       msg_bype,
    input  logic             wr_en,
    output logic [IDX_W-1:0] cw_out,
    output logic             cw_rdy,
    output logic             cw_done
);

    state_t           state;
    logic             pending;
    logic [POS_W-1:0] pos;
    logic             buf_full;
    logic             buf_clr;
    logic [K-1:0]     msg;
    logic [NPAR-1:0]  par;
    logic [N-1:0]     cw;

    // Tap stage between the wide position mux and the output register.
    logic             stage_vld;
    logic             stage_bit;
    logic [IDX_W-1:0] stage_pos;
    logic             stage_last;
    logic             drain_last;

    assign buf_clr = (state == DONE) && drain_last;

    cw_msg_buffer u_msg_buffer (
        .clk     (clk),
        .rst_b   (rst_b),
        .wr_en   (wr_en && (state == IDLE)),
        .wr_byte (msg_bype),
        .clr     (buf_clr),
        .full    (buf_full),
        .msg     (msg)
    );

    for (genvar j = 0; j < NPAR; j++) begin : g_par
        assign par[j] = msg[j] ^ msg[tap_idx(j, OFS1)] ^ msg[tap_idx(j, OFS2)];
    end

    assign cw = {par, msg};

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state      <= IDLE;
            pending    <= 1'b0;
            pos        <= '0;
            stage_vld  <= 1'b0;
            stage_bit  <= 1'b0;
            stage_pos  <= '0;
            stage_last <= 1'b0;
            drain_last <= 1'b0;
            cw_out     <= '0;
            cw_rdy     <= 1'b0;
            cw_done    <= 1'b0;
        end else begin
            stage_vld  <= 1'b0;
            stage_last <= 1'b0;
            drain_last <= stage_last;
            cw_rdy     <= 1'b0;
            cw_done    <= drain_last;

            if (stage_vld) begin
                cw_rdy <= stage_bit;
                if (stage_bit) begin
                    cw_out <= stage_pos;
                end
            end

            case (state)
                IDLE: begin
                    if (pending && buf_full) begin
                        state   <= RUN;
                        pos     <= '0;
                        pending <= 1'b0;
                    end else if (start) begin
                        pending <= 1'b1;
                    end
                end
                RUN: begin
                    stage_vld <= 1'b1;
                    stage_bit <= cw[pos];
                    stage_pos <= IDX_W'(pos);
                    if (pos == POS_W'(N - 1)) begin
                        stage_last <= 1'b1;
                        state      <= DONE;
                    end else begin
                        pos <= pos + 1'b1;
                    end
                end
                DONE: begin
                    if (drain_last) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cw_encode.sv
// Bench for cw_encode: golden codeword model from the encoding equations,
// cycle-timed expectations and a per-cycle output compare.
module tb_cw_encode;
    import cw_encode_pkg::*;

    typedef logic [7:0] msg_t [NBYTES];

    logic             clk;
    logic             rst_b;
    logic             start;
    logic [7:0]       msg_bype;
    logic             wr_en;
    logic [IDX_W-1:0] cw_out;
    logic             cw_rdy;
    logic             cw_done;

    int  cyc;
    int  checks;
    int  errors;
    int  exp_idx [int];
    bit  exp_done [int];
    int  last_out;
    int  obs [$];
    int  gold [$];
    int  lit [$];

    cw_encode dut (
        .clk      (clk),
        .rst_b    (rst_b),
        .start    (start),
        .msg_bype (msg_bype),
        .wr_en    (wr_en),
        .cw_out   (cw_out),
        .cw_rdy   (cw_rdy),
        .cw_done  (cw_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output after edge e is sampled at the following negedge, where cyc == e.
    always @(negedge clk) begin
        bit er;
        bit ed;
        er = (exp_idx.exists(cyc) != 0);
        ed = (exp_done.exists(cyc) != 0);
        if (er) last_out = exp_idx[cyc];
        checks++;
        if (cw_rdy !== er) begin
            errors++;
            $display("FAIL rdy cyc=%0d got=%b want=%b", cyc, cw_rdy, er);
        end
        checks++;
        if (cw_out !== IDX_W'(last_out)) begin
            errors++;
            $display("FAIL out cyc=%0d got=%0d want=%0d", cyc, cw_out, last_out);
        end
        checks++;
        if (cw_done !== ed) begin
            errors++;
            $display("FAIL done cyc=%0d got=%b want=%b", cyc, cw_done, ed);
        end
        if (cw_rdy === 1'b1) obs.push_back(int'(cw_out));
    end

    function automatic void golden(input msg_t b);
        bit m [K];
        gold.delete();
        for (int i = 0; i < NBYTES; i++)
            for (int k = 0; k < 8; k++)
                m[8*i + k] = b[i][7-k];
        for (int p = 0; p < K; p++)
            if (m[p]) gold.push_back(p);
        for (int j = 0; j < N - K; j++)
            if (m[j] ^ m[(j + OFS1) % K] ^ m[(j + OFS2) % K]) gold.push_back(K + j);
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pin(input string name);
        checks++;
        if (gold.size() != lit.size()) begin
            errors++;
            $display("FAIL pin_%s size got=%0d want=%0d", name, gold.size(), lit.size());
        end else begin
            for (int i = 0; i < lit.size(); i++) begin
                if (gold[i] != lit[i]) begin
                    errors++;
                    $display("FAIL pin_%s [%0d] got=%0d want=%0d", name, i, gold[i], lit[i]);
                end
            end
        end
    endtask

    task automatic compare_list(input string name);
        checks++;
        if (obs.size() != gold.size()) begin
            errors++;
            $display("FAIL list_%s count got=%0d want=%0d", name, obs.size(), gold.size());
        end else begin
            for (int i = 0; i < gold.size(); i++) begin
                if (obs[i] != gold[i]) begin
                    errors++;
                    $display("FAIL list_%s [%0d] got=%0d want=%0d", name, i, obs[i], gold[i]);
                end
            end
        end
    endtask

    // start_from >= 0: start raised with that byte and held to the last byte.
    // start_from <  0: start pulsed gap idle cycles after loading.
    task automatic encode(input string name, input msg_t b, input int start_from,
                          input int gap, input bit junk, input int abort_at);
        int es;
        int ef;
        int acc;
        es = -1;
        golden(b);
        obs.delete();
        for (int i = 0; i < NBYTES; i++) begin
            tick();
            wr_en    = 1'b1;
            msg_bype = b[i];
            if (start_from >= 0 && i >= start_from) begin
                start = 1'b1;
                if (es < 0) es = cyc + 1;
            end
        end
        ef = cyc + 1;
        tick();
        wr_en = 1'b0;
        start = 1'b0;
        if (start_from < 0) begin
            repeat (gap) tick();
            start = 1'b1;
            es    = cyc + 1;
            tick();
            start = 1'b0;
        end
        acc = ((es > ef) ? es : ef) + 1;
        foreach (gold[i]) exp_idx[acc + 2 + gold[i]] = gold[i];
        exp_done[acc + N + 2] = 1'b1;
        if (junk) begin
            repeat (3) tick();
            for (int i = 0; i < 20; i++) begin
                wr_en    = 1'b1;
                msg_bype = 8'hFF;
                start    = 1'b1;
                tick();
            end
            wr_en = 1'b0;
            start = 1'b0;
        end
        if (abort_at >= 0) begin
            while (cyc < acc + 2 + abort_at) tick();
            rst_b = 1'b0;
            exp_idx.delete();
            exp_done.delete();
            last_out = 0;
            repeat (3) tick();
            rst_b = 1'b1;
            repeat (2) tick();
        end else begin
            while (cyc < acc + N + 5) tick();
            compare_list(name);
        end
    endtask

    initial begin
        msg_t b;
        checks   = 0;
        errors   = 0;
        last_out = 0;
        rst_b    = 1'b0;
        start    = 1'b0;
        wr_en    = 1'b0;
        msg_bype = 8'h00;
        repeat (3) tick();
        rst_b = 1'b1;
        tick();

        foreach (b[i]) b[i] = 8'h00;
        b[0] = 8'h80;
        golden(b);
        lit = '{0, 184, 246};
        pin("m0");
        encode("m0", b, -1, 0, 1'b0, -1);

        foreach (b[i]) b[i] = 8'h00;
        b[22] = 8'h01;
        golden(b);
        lit = '{183, 245};
        pin("m183");
        encode("m183", b, -1, 3, 1'b0, -1);

        foreach (b[i]) b[i] = 8'h00;
        b[8] = 8'h02;
        golden(b);
        lit = '{70, 193, 254};
        pin("m70");
        encode("m70", b, -1, 1, 1'b0, -1);

        foreach (b[i]) b[i] = 8'h00;
        b[0] = 8'h80;
        b[7] = 8'h04;
        golden(b);
        lit = '{0, 61, 245, 246};
        pin("m0_m61");
        encode("m0_m61", b, -1, 2, 1'b0, -1);

        foreach (b[i]) b[i] = 8'h00;
        b[3]  = 8'h5A;
        b[15] = 8'hC3;
        b[22] = 8'h81;
        encode("early_start", b, 1, 0, 1'b1, -1);

        foreach (b[i]) b[i] = 8'h00;
        encode("zero", b, -1, 4, 1'b0, -1);

        foreach (b[i]) b[i] = 8'($urandom);
        encode("abort", b, -1, 0, 1'b0, 140);
        encode("reload", b, -1, 2, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
